// File: rtl/ifetch_unit_if.sv
// Instruction bus between fetch and memory: one read request,
// accepted by addr_ok, answered by data_ok with the word.
interface ifetch_unit_if #(
    parameter int AW = 64,
    parameter int IW = 32
);
    logic          ireq_valid;
    logic [AW-1:0] ireq_addr;
    logic          iresp_addr_ok;
    logic          iresp_data_ok;
    logic [IW-1:0] iresp_data;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: one outstanding ibus read per PC, buffers the word
// and presents {pc,instr} to decode; flushes drop in-flight data.
module ifetch_unit #(
    parameter int            AW       = 64,
    parameter int            IW       = 32,
    parameter logic [IW-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          flush,
    input  logic          id_ready,
    ifetch_unit_if.master ibus,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [IW-1:0] if_instr,
    output logic          if_misalign,
    output logic          pc_advance,
    output logic [31:0]   stall_cycles
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, HOLD, DROP
    } state_t;

    state_t        state, state_n;
    logic          drop, drop_n;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] instr_q;
    logic          mis_q;
    logic          valid_q;
    logic [31:0]   stall_q;
    logic          latch, cap, nop, advance;

    wire addr_ok = ibus.iresp_addr_ok;
    wire data_ok = ibus.iresp_data_ok;

    always_comb begin
        state_n = state;
        drop_n  = drop;
        latch   = 1'b0;
        cap     = 1'b0;
        nop     = 1'b0;
        advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush) begin
                    latch = 1'b1;
                    if (pc[1:0] != 2'b00) begin
                        nop     = 1'b1;
                        state_n = HOLD;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (addr_ok) begin
                    if (data_ok) begin
                        if (drop || flush) begin
                            drop_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            cap     = 1'b1;
                            state_n = HOLD;
                        end
                    end else if (drop || flush) begin
                        drop_n  = 1'b1;
                        state_n = DROP;
                    end else begin
                        state_n = WAIT;
                    end
                end else if (flush) begin
                    drop_n = 1'b1;
                end
            end
            WAIT: begin
                if (data_ok) begin
                    if (flush) begin
                        state_n = IDLE;
                    end else begin
                        cap     = 1'b1;
                        state_n = HOLD;
                    end
                end else if (flush) begin
                    drop_n  = 1'b1;
                    state_n = DROP;
                end
            end
            DROP: begin
                if (data_ok) begin
                    drop_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            HOLD: begin
                // a redirect wins over a same-cycle decode accept
                if (flush) begin
                    state_n = IDLE;
                end else if (id_ready) begin
                    advance = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                drop_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            drop     <= 1'b0;
            req_addr <= '0;
            instr_q  <= '0;
            mis_q    <= 1'b0;
            valid_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            state   <= state_n;
            drop    <= drop_n;
            valid_q <= (state_n == HOLD);
            if (latch) req_addr <= pc;
            if (cap) begin
                instr_q <= ibus.iresp_data;
                mis_q   <= 1'b0;
            end else if (nop) begin
                instr_q <= NOP_INST;
                mis_q   <= 1'b1;
            end
            if ((state == REQ || state == WAIT || state == DROP)
                && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign ibus.ireq_valid = (state == REQ);
    assign ibus.ireq_addr  = {req_addr[AW-1:2], 2'b00};
    assign if_valid        = valid_q;
    assign if_pc           = req_addr;
    assign if_instr        = instr_q;
    assign if_misalign     = mis_q;
    assign pc_advance      = advance;
    assign stall_cycles    = stall_q;

    // a response is only legal while one is outstanding
    a_data_ok_legal: assert property (
        @(posedge clk) disable iff (!reset)
        data_ok |-> (state == WAIT || state == DROP
                     || (state == REQ && addr_ok))
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: bus responses driven step by step,
// expected decode slots queued and compared when if_valid appears.
module tb_ifetch_unit;

    localparam int AW = 64;
    localparam int IW = 32;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic          mis;
    } slot_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          flush;
    logic          id_ready;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_instr;
    logic          if_misalign;
    logic          pc_advance;
    logic [31:0]   stall_cycles;

    int checks = 0;
    int errors = 0;
    slot_t sb[$];

    ifetch_unit_if #(.AW(AW), .IW(IW)) ibus ();

    ifetch_unit #(.AW(AW), .IW(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .flush        (flush),
        .id_ready     (id_ready),
        .ibus         (ibus),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_misalign  (if_misalign),
        .pc_advance   (pc_advance),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic a, input logic d,
                       input logic [IW-1:0] w);
        ibus.iresp_addr_ok = a;
        ibus.iresp_data_ok = d;
        ibus.iresp_data    = w;
    endtask

    task automatic push(input logic [AW-1:0] p, input logic [IW-1:0] w,
                        input logic m);
        slot_t s;
        s.pc = p;
        s.instr = w;
        s.mis = m;
        sb.push_back(s);
    endtask

    task automatic expect_slot(input string tag, input int budget);
        slot_t s;
        int n = 0;
        while (!if_valid && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, if_valid, 1);
        chk({tag, "_sb"}, sb.size() != 0, 1);
        if (if_valid && sb.size() != 0) begin
            s = sb.pop_front();
            chk({tag, "_pc"}, if_pc, s.pc);
            chk({tag, "_instr"}, if_instr, s.instr);
            chk({tag, "_mis"}, if_misalign, s.mis);
        end
    endtask

    task automatic accept(input string tag);
        id_ready = 1'b1;
        #1;
        chk({tag, "_adv"}, pc_advance, 1);
        tick();
        id_ready = 1'b0;
        #1;
        chk({tag, "_adv_once"}, pc_advance, 0);
        chk({tag, "_drop_valid"}, if_valid, 0);
    endtask

    initial begin
        reset = 1'b0;
        pc = 64'h8000_0000;
        flush = 1'b0;
        id_ready = 1'b0;
        bus(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", if_valid, 0);
        chk("rst_ireq_valid", ibus.ireq_valid, 0);
        chk("rst_ireq_addr", ibus.ireq_addr, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_adv", pc_advance, 0);
        chk("rst_instr", if_instr, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: basic fetch, addr/data ok one cycle after request
        tick();
        chk("t1_req", ibus.ireq_valid, 1);
        chk("t1_addr", ibus.ireq_addr, 64'h8000_0000);
        tick();
        bus(1'b1, 1'b1, 32'h0010_0093);
        push(64'h8000_0000, 32'h0010_0093, 1'b0);
        tick();
        bus(1'b0, 1'b0, '0);
        expect_slot("t1", 4);
        accept("t1");
        chk("t1_stall", stall_cycles, 2);

        // 2: decode back-pressure
        pc = 64'h8000_0004;
        tick();
        chk("t2_addr", ibus.ireq_addr, 64'h8000_0004);
        bus(1'b1, 1'b1, 32'h0040_0213);
        push(64'h8000_0004, 32'h0040_0213, 1'b0);
        tick();
        bus(1'b0, 1'b0, '0);
        expect_slot("t2", 4);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", if_valid, 1);
            chk("t2_hold_instr", if_instr, 32'h0040_0213);
            chk("t2_hold_pc", if_pc, 64'h8000_0004);
            chk("t2_no_req", ibus.ireq_valid, 0);
            chk("t2_no_adv", pc_advance, 0);
            tick();
        end
        accept("t2");

        // 3: flush in WAIT, late response dropped
        pc = 64'h8000_0008;
        tick();
        chk("t3_addr", ibus.ireq_addr, 64'h8000_0008);
        bus(1'b1, 1'b0, '0);
        tick();
        bus(1'b0, 1'b0, '0);
        chk("t3_wait_noreq", ibus.ireq_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc = 64'h8000_0100;
        for (int i = 0; i < 2; i++) begin
            chk("t3_drop_novalid", if_valid, 0);
            tick();
        end
        bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        bus(1'b0, 1'b0, '0);
        chk("t3_dropped", if_valid, 0);
        tick();
        chk("t3_newaddr", ibus.ireq_addr, 64'h8000_0100);
        bus(1'b1, 1'b1, 32'h0020_0113);
        push(64'h8000_0100, 32'h0020_0113, 1'b0);
        tick();
        bus(1'b0, 1'b0, '0);
        expect_slot("t3", 4);
        accept("t3");
        chk("t3_stall", stall_cycles, 9);

        // 4: flush in REQ with addr_ok held off
        pc = 64'h8000_0104;
        tick();
        chk("t4_addr", ibus.ireq_addr, 64'h8000_0104);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pc = 64'h8000_0200;
        for (int i = 0; i < 3; i++) begin
            chk("t4_req_held", ibus.ireq_valid, 1);
            chk("t4_addr_held", ibus.ireq_addr, 64'h8000_0104);
            tick();
        end
        bus(1'b1, 1'b0, '0);
        tick();
        bus(1'b0, 1'b0, '0);
        chk("t4_drop_noreq", ibus.ireq_valid, 0);
        chk("t4_drop_novalid", if_valid, 0);
        bus(1'b0, 1'b1, 32'hBAD0_BAD0);
        tick();
        bus(1'b0, 1'b0, '0);
        chk("t4_dropped", if_valid, 0);
        tick();
        chk("t4_newaddr", ibus.ireq_addr, 64'h8000_0200);
        bus(1'b1, 1'b1, 32'h0030_0193);
        push(64'h8000_0200, 32'h0030_0193, 1'b0);
        tick();
        bus(1'b0, 1'b0, '0);
        expect_slot("t4", 4);
        accept("t4");
        chk("t4_stall", stall_cycles, 16);

        // 5: misaligned PC, no bus traffic
        pc = 64'h8000_0202;
        push(64'h8000_0202, 32'h0000_0013, 1'b1);
        tick();
        chk("t5_noreq", ibus.ireq_valid, 0);
        expect_slot("t5", 4);
        accept("t5");
        chk("t5_stall", stall_cycles, 16);

        // flush beats id_ready in HOLD
        pc = 64'h8000_0300;
        tick();
        bus(1'b1, 1'b1, 32'h0050_0293);
        push(64'h8000_0300, 32'h0050_0293, 1'b0);
        tick();
        bus(1'b0, 1'b0, '0);
        expect_slot("hf", 4);
        flush = 1'b1;
        id_ready = 1'b1;
        #1;
        chk("hf_no_adv", pc_advance, 0);
        tick();
        flush = 1'b0;
        id_ready = 1'b0;
        chk("hf_valid_gone", if_valid, 0);
        chk("hf_stall", stall_cycles, 17);

        // 6: reset asserted in WAIT
        pc = 64'h8000_0400;
        tick();
        bus(1'b1, 1'b0, '0);
        tick();
        bus(1'b0, 1'b0, '0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_ireq_valid", ibus.ireq_valid, 0);
        chk("t6_ireq_addr", ibus.ireq_addr, 0);
        chk("t6_if_valid", if_valid, 0);
        chk("t6_if_pc", if_pc, 0);
        chk("t6_stall", stall_cycles, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t6_refetch", ibus.ireq_valid, 1);
        chk("t6_addr", ibus.ireq_addr, 64'h8000_0400);
        bus(1'b1, 1'b1, 32'h0060_0313);
        push(64'h8000_0400, 32'h0060_0313, 1'b0);
        tick();
        bus(1'b0, 1'b0, '0);
        expect_slot("t6", 4);
        accept("t6");
        chk("t6_stall_after", stall_cycles, 1);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
